// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared card-game constants, types and FSM state encodings
package game_pkg;

  localparam int CARD_IDX_W = 4;
  localparam int MAX_CARDS  = 16;
  localparam int COORD_W    = 13;

  // Default board geometry, in pixels
  localparam int DEF_COLS   = 4;
  localparam int DEF_ROWS   = 4;
  localparam int DEF_X0     = 64;
  localparam int DEF_Y0     = 40;
  localparam int DEF_CARD_W = 150;
  localparam int DEF_CARD_H = 150;
  localparam int DEF_GAP    = 20;

  // State encodings shared with the game FSM
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_SCAN    = 3'd2;
  localparam logic [2:0] ST_RESULT  = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  typedef logic [CARD_IDX_W-1:0] card_idx_t;
  typedef logic [MAX_CARDS-1:0]  card_mask_t;
  typedef logic [COORD_W-1:0]    coord_t;

  // Bits 0..n-1 set; used to keep unused card slots permanently zero
  function automatic card_mask_t valid_mask(input int n);
    card_mask_t m;
    m = '0;
    for (int i = 0; i < MAX_CARDS; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Linear card index row*cols+col
  function automatic card_idx_t card_index(input card_idx_t row, input card_idx_t col,
                                           input int cols);
    return card_idx_t'(int'(row) * cols + int'(col));
  endfunction

endpackage

// File: rtl/card_hit_scan.sv
// rtl/card_hit_scan.sv - serial column/row hit search over the card grid
module card_hit_scan
  import game_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int X0     = DEF_X0,
  parameter int Y0     = DEF_Y0,
  parameter int CARD_W = DEF_CARD_W,
  parameter int CARD_H = DEF_CARD_H,
  parameter int GAP    = DEF_GAP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        run,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic        last,
  output logic        done,
  output logic        col_hit,
  output logic        row_hit,
  output card_idx_t   col,
  output card_idx_t   row
);

  localparam int     SCAN_LEN = (COLS > ROWS) ? COLS : ROWS;
  localparam coord_t PITCH_X  = coord_t'(CARD_W + GAP);
  localparam coord_t PITCH_Y  = coord_t'(CARD_H + GAP);

  coord_t     x_l, y_l, x_off, y_off;
  logic [3:0] k;
  logic       col_in, row_in;

  assign last = (k == 4'(SCAN_LEN - 1));

  // Window test for column/row k; 13-bit compare so the far edge never wraps
  always_comb begin
    col_in = ({1'b0, k} < 5'(COLS)) && (x_l >= x_off) && (x_l < x_off + coord_t'(CARD_W));
    row_in = ({1'b0, k} < 5'(ROWS)) && (y_l >= y_off) && (y_l < y_off + coord_t'(CARD_H));
  end

  // Latch the click position on start, then step one column/row per cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_l     <= '0;
      y_l     <= '0;
      x_off   <= '0;
      y_off   <= '0;
      k       <= '0;
      done    <= 1'b0;
      col_hit <= 1'b0;
      row_hit <= 1'b0;
      col     <= '0;
      row     <= '0;
    end else if (start) begin
      x_l     <= {1'b0, xpos};
      y_l     <= {1'b0, ypos};
      x_off   <= coord_t'(X0);
      y_off   <= coord_t'(Y0);
      k       <= '0;
      done    <= 1'b0;
      col_hit <= 1'b0;
      row_hit <= 1'b0;
      col     <= '0;
      row     <= '0;
    end else if (run) begin
      if (col_in) begin
        col_hit <= 1'b1;
        col     <= k;
      end
      if (row_in) begin
        row_hit <= 1'b1;
        row     <= k;
      end
      x_off <= x_off + PITCH_X;
      y_off <= y_off + PITCH_Y;
      k     <= k + 4'd1;
      done  <= last;
    end
  end

endmodule

// File: rtl/card_click_responder.sv
// rtl/card_click_responder.sv - click-to-card responder with reveal mask and pair tracking
module card_click_responder
  import game_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int X0     = DEF_X0,
  parameter int Y0     = DEF_Y0,
  parameter int CARD_W = DEF_CARD_W,
  parameter int CARD_H = DEF_CARD_H,
  parameter int GAP    = DEF_GAP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wait_for_click_en,
  input  logic        write_card_en,
  input  logic        hide_pair_en,
  input  logic        keep_pair_en,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  output logic        card_pressed,
  output logic [3:0]  card_idx,
  output logic [3:0]  first_idx,
  output logic [3:0]  second_idx,
  output logic [1:0]  pair_cnt,
  output logic [15:0] revealed_mask,
  output logic        go_to_compare
);

  localparam card_mask_t VALID = valid_mask(COLS * ROWS);

  logic [2:0] state;
  logic       mouse_prev;
  logic       click;
  logic       scan_start, scan_run, scan_last, scan_done;
  logic       col_hit, row_hit;
  card_idx_t  col, row, hit_idx;
  logic       hit_ok;
  card_mask_t mask_next;

  assign click      = mouse_left & ~mouse_prev;
  assign scan_start = (state == ST_ARMED) && wait_for_click_en && click;
  assign scan_run   = (state == ST_SCAN) && wait_for_click_en;
  assign hit_idx    = card_index(row, col, COLS);
  assign hit_ok     = scan_done && col_hit && row_hit && !revealed_mask[hit_idx];

  card_hit_scan #(
    .COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0),
    .CARD_W(CARD_W), .CARD_H(CARD_H), .GAP(GAP)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .start   (scan_start),
    .run     (scan_run),
    .xpos    (xpos),
    .ypos    (ypos),
    .last    (scan_last),
    .done    (scan_done),
    .col_hit (col_hit),
    .row_hit (row_hit),
    .col     (col),
    .row     (row)
  );

  // Button history for rising-edge click detection
  always_ff @(posedge clk) begin
    if (!rst) mouse_prev <= 1'b0;
    else      mouse_prev <= mouse_left;
  end

  // Click handshake FSM; card_pressed is a single registered pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      card_pressed <= 1'b0;
      card_idx     <= '0;
    end else begin
      card_pressed <= 1'b0;
      case (state)
        ST_IDLE:    if (wait_for_click_en) state <= ST_ARMED;
        ST_ARMED: begin
          if (!wait_for_click_en) state <= ST_IDLE;
          else if (click)         state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (!wait_for_click_en) state <= ST_IDLE;
          else if (scan_last)     state <= ST_RESULT;
        end
        ST_RESULT: begin
          if (hit_ok) begin
            card_pressed <= 1'b1;
            card_idx     <= hit_idx;
            state        <= ST_RELEASE;
          end else begin
            state <= ST_ARMED;
          end
        end
        ST_RELEASE: if (!mouse_left) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Next reveal mask: hide beats keep beats write; only pair slots in use are cleared
  always_comb begin
    mask_next = revealed_mask;
    if (hide_pair_en) begin
      if (pair_cnt != 2'd0) mask_next[first_idx]  = 1'b0;
      if (pair_cnt == 2'd2) mask_next[second_idx] = 1'b0;
    end else if (!keep_pair_en && write_card_en && (pair_cnt != 2'd2)) begin
      mask_next[card_idx] = 1'b1;
    end
    mask_next = mask_next & VALID;
  end

  // Pair bookkeeping, mask register and the registered all-revealed flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      first_idx     <= '0;
      second_idx    <= '0;
      pair_cnt      <= '0;
      revealed_mask <= '0;
      go_to_compare <= 1'b0;
    end else begin
      revealed_mask <= mask_next;
      go_to_compare <= (revealed_mask == VALID);
      if (hide_pair_en || keep_pair_en) begin
        pair_cnt <= 2'd0;
      end else if (write_card_en) begin
        if (pair_cnt == 2'd0) begin
          first_idx <= card_idx;
          pair_cnt  <= 2'd1;
        end else if (pair_cnt == 2'd1) begin
          second_idx <= card_idx;
          pair_cnt   <= 2'd2;
        end
      end
    end
  end

endmodule

// File: tb/tb_card_click_responder.sv
// tb/tb_card_click_responder.sv - self-checking bench for card_click_responder
module tb_card_click_responder;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wait_for_click_en = 1'b0;
  logic        write_card_en = 1'b0;
  logic        hide_pair_en = 1'b0;
  logic        keep_pair_en = 1'b0;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic        mouse_left = 1'b0;
  logic        card_pressed;
  logic [3:0]  card_idx, first_idx, second_idx;
  logic [1:0]  pair_cnt;
  logic [15:0] revealed_mask;
  logic        go_to_compare;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Monitor cycles from the click edge to the first sample showing the pulse
  localparam int LAT = 5;

  typedef struct { int idx; int due; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_pulse = 1'b0;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    bit          pulse;
    int          idx;
  } vec_t;
  vec_t vecs[11];
  int   last_idx;

  card_click_responder dut (
    .clk               (clk),
    .rst               (rst),
    .wait_for_click_en (wait_for_click_en),
    .write_card_en     (write_card_en),
    .hide_pair_en      (hide_pair_en),
    .keep_pair_en      (keep_pair_en),
    .xpos              (xpos),
    .ypos              (ypos),
    .mouse_left        (mouse_left),
    .card_pressed      (card_pressed),
    .card_idx          (card_idx),
    .first_idx         (first_idx),
    .second_idx        (second_idx),
    .pair_cnt          (pair_cnt),
    .revealed_mask     (revealed_mask),
    .go_to_compare     (go_to_compare)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse monitor: every pulse must match the scoreboard head, never back-to-back
  always @(posedge clk) begin
    #1;
    if (card_pressed === 1'b1) begin
      check("no_double_pulse", {31'd0, prev_pulse}, 32'd0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got card_pressed=1 idx=%0d, expected no pulse (t=%0t)",
                 card_idx, $time);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_idx", {28'd0, card_idx}, mon_e.idx);
        check("pulse_cycle", cyc, mon_e.due);
      end
    end
    prev_pulse = card_pressed;
  end

  task automatic click(input logic [11:0] x, input logic [11:0] y, input bit pulse,
                       input int idx, input int hold);
    @(negedge clk);
    xpos = x;
    ypos = y;
    mouse_left = 1'b1;
    @(posedge clk);
    #1;
    if (pulse) sb.push_back('{idx, cyc + LAT});
    repeat (hold) @(posedge clk);
    @(negedge clk);
    mouse_left = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pulse_drained", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic ctl(input bit h, input bit k, input bit w);
    @(negedge clk);
    hide_pair_en  = h;
    keep_pair_en  = k;
    write_card_en = w;
    @(posedge clk);
    #1;
    hide_pair_en  = 1'b0;
    keep_pair_en  = 1'b0;
    write_card_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pressed"}, {31'd0, card_pressed}, 32'd0);
    check({tag, "_idx"}, {28'd0, card_idx}, 32'd0);
    check({tag, "_first"}, {28'd0, first_idx}, 32'd0);
    check({tag, "_second"}, {28'd0, second_idx}, 32'd0);
    check({tag, "_pair_cnt"}, {30'd0, pair_cnt}, 32'd0);
    check({tag, "_mask"}, {16'd0, revealed_mask}, 32'd0);
    check({tag, "_go"}, {31'd0, go_to_compare}, 32'd0);
    check({tag, "_state"}, {29'd0, dut.state}, {29'd0, ST_IDLE});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Click vectors: hits, gap misses, grid edges and far-out coordinates
    vecs[0]  = '{12'd244,  12'd45,   1'b1, 1};
    vecs[1]  = '{12'd219,  12'd45,   1'b0, 0};
    vecs[2]  = '{12'd64,   12'd40,   1'b1, 0};
    vecs[3]  = '{12'd213,  12'd40,   1'b1, 0};
    vecs[4]  = '{12'd214,  12'd40,   1'b0, 0};
    vecs[5]  = '{12'd723,  12'd699,  1'b1, 15};
    vecs[6]  = '{12'd724,  12'd699,  1'b0, 0};
    vecs[7]  = '{12'd10,   12'd10,   1'b0, 0};
    vecs[8]  = '{12'd414,  12'd220,  1'b1, 6};
    vecs[9]  = '{12'd4095, 12'd4095, 1'b0, 0};
    vecs[10] = '{12'd63,   12'd100,  1'b0, 0};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    @(negedge clk);
    rst = 1'b1;
    wait_for_click_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("armed", {29'd0, dut.state}, {29'd0, ST_ARMED});

    last_idx = 0;
    for (int i = 0; i < 11; i++) begin
      click(vecs[i].x, vecs[i].y, vecs[i].pulse, vecs[i].idx, 8);
      if (vecs[i].pulse) last_idx = vecs[i].idx;
      check($sformatf("vec%0d_idx_held", i), {28'd0, card_idx}, last_idx);
      check($sformatf("vec%0d_rearmed", i), {29'd0, dut.state}, {29'd0, ST_ARMED});
    end

    // Long button holds: one evaluation per press
    click(12'd219, 12'd45, 1'b0, 0, 100);
    check("gap_hold_armed", {29'd0, dut.state}, {29'd0, ST_ARMED});
    click(12'd244, 12'd45, 1'b1, 1, 100);

    // Build a pair 1/6, then revealed card 6 is ignored and a third write dropped
    ctl(1'b0, 1'b0, 1'b1);
    check("w1_mask", {16'd0, revealed_mask}, 32'h0002);
    click(12'd414, 12'd220, 1'b1, 6, 8);
    ctl(1'b0, 1'b0, 1'b1);
    check("pair_first", {28'd0, first_idx}, 32'd1);
    check("pair_second", {28'd0, second_idx}, 32'd6);
    check("pair_cnt2", {30'd0, pair_cnt}, 32'd2);
    check("pair_mask", {16'd0, revealed_mask}, 32'h0042);
    click(12'd414, 12'd220, 1'b0, 0, 8);
    check("revealed_idx_held", {28'd0, card_idx}, 32'd6);
    click(12'd64, 12'd40, 1'b1, 0, 8);
    ctl(1'b0, 1'b0, 1'b1);
    check("full_pair_mask", {16'd0, revealed_mask}, 32'h0042);
    check("full_pair_second", {28'd0, second_idx}, 32'd6);
    check("full_pair_cnt", {30'd0, pair_cnt}, 32'd2);

    // Hide and write together: hide wins, write dropped
    ctl(1'b1, 1'b0, 1'b1);
    check("hide_mask", {16'd0, revealed_mask}, 32'h0000);
    check("hide_pair_cnt", {30'd0, pair_cnt}, 32'd0);

    // Enable dropped mid-scan: abort without a pulse
    @(negedge clk);
    xpos = 12'd64;
    ypos = 12'd40;
    mouse_left = 1'b1;
    @(posedge clk);
    repeat (2) @(negedge clk);
    wait_for_click_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_idle", {29'd0, dut.state}, {29'd0, ST_IDLE});
    @(negedge clk);
    mouse_left = 1'b0;
    wait_for_click_en = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_rearmed", {29'd0, dut.state}, {29'd0, ST_ARMED});

    // Reveal all cards pair by pair; exercise go_to_compare rise and fall
    for (int i = 0; i < 16; i++) begin
      click(12'(64 + (i % 4) * 170 + 75), 12'(40 + (i / 4) * 170 + 75), 1'b1, i, 8);
      ctl(1'b0, 1'b0, 1'b1);
      if (i == 15) begin
        check("full_mask", {16'd0, revealed_mask}, 32'hFFFF);
        check("go_not_yet", {31'd0, go_to_compare}, 32'd0);
        @(posedge clk);
        #1;
        check("go_rise", {31'd0, go_to_compare}, 32'd1);
        ctl(1'b1, 1'b0, 1'b0);
        check("hide_last_mask", {16'd0, revealed_mask}, 32'h3FFF);
        @(posedge clk);
        #1;
        check("go_fall", {31'd0, go_to_compare}, 32'd0);
        click(12'(64 + 2 * 170 + 75), 12'(40 + 3 * 170 + 75), 1'b1, 14, 8);
        ctl(1'b0, 1'b0, 1'b1);
        click(12'(64 + 3 * 170 + 75), 12'(40 + 3 * 170 + 75), 1'b1, 15, 8);
        ctl(1'b0, 1'b0, 1'b1);
        ctl(1'b0, 1'b1, 1'b0);
      end else if (i % 2 == 1) begin
        ctl(1'b0, 1'b1, 1'b0);
        check($sformatf("keep%0d_cnt", i), {30'd0, pair_cnt}, 32'd0);
      end
    end
    check("final_mask", {16'd0, revealed_mask}, 32'hFFFF);
    check("final_go", {31'd0, go_to_compare}, 32'd1);

    // Reset in the middle of a scan clears everything
    @(negedge clk);
    xpos = 12'd64;
    ypos = 12'd40;
    mouse_left = 1'b1;
    @(posedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midscan_reset");
    @(negedge clk);
    rst = 1'b1;
    mouse_left = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post_reset_mask", {16'd0, revealed_mask}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
